// File: rtl/rotate_buf_pkg.sv
// Shared constants for the rotation frame-buffer sequencer: drain FSM encoding,
// bank index type and default tile geometry.
package rotate_buf_pkg;
  localparam int DEF_ROWS   = 8;
  localparam int DEF_COLS   = 16;
  localparam int BANK_WORDS = DEF_ROWS * DEF_COLS;
  localparam int ROW_W      = $clog2(DEF_ROWS);
  localparam int COL_W      = $clog2(DEF_COLS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef logic bank_t;
endpackage

// File: rtl/rotate_buf_ctrl_if.sv
// Input word stream, output tile stream and tile-done strobe of the frame-buffer
// sequencer; slave is the sequencer side.
interface rotate_buf_ctrl_if #(parameter int DATA_W = 256);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              tile_done;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_last, tile_done);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_last, tile_done);
endinterface

// File: rtl/rotate_out_skid.sv
// Two-entry output buffer with empty-path bypass, so a RAM word can leave the
// cycle it arrives; occupancy feeds the read-issue throttle.
module rotate_out_skid #(
  parameter int W = 257
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_occ
);
  logic [1:0][W-1:0] r_mem;
  logic              r_rd;
  logic              r_wr;
  logic [1:0]        r_occ;
  logic              w_empty;
  logic              w_pop;
  logic              w_store;

  assign w_empty = (r_occ == 2'd0);
  assign o_valid = !w_empty || i_push;
  assign o_data  = w_empty ? i_data : r_mem[r_rd];
  assign o_occ   = r_occ;
  assign w_pop   = !w_empty && i_ready;
  // An arriving word only lands in storage if it could not bypass straight out.
  assign w_store = i_push && !(w_empty && i_ready);

  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
      r_occ <= 2'd0;
    end else begin
      if (w_store) r_wr <= ~r_wr;
      if (w_pop)   r_rd <= ~r_rd;
      case ({w_store, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end
endmodule

// File: rtl/rotate_buf_ctrl.sv
// Ping-pong tile sequencer for the rotation frame buffer: fills one bank from the
// input stream while the other drains linearly or column-major.
module rotate_buf_ctrl
  import rotate_buf_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 256,
  parameter int ROWS   = 8,
  parameter int COLS   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_rot_en,
  rotate_buf_ctrl_if.slave  bus,
  output logic [1:0]        o_bank_full,
  output logic              o_ram_wr_en,
  output logic [ADDR_W-1:0] o_ram_wr_addr,
  output logic [DATA_W-1:0] o_ram_wr_data,
  output logic [ADDR_W-1:0] o_ram_rd_addr,
  input  logic [DATA_W-1:0] i_ram_rd_data
);
  localparam int ROWB = $clog2(ROWS);
  localparam int COLB = $clog2(COLS);
  localparam int BW   = ADDR_W - 1;

  logic            w_clr;
  bank_t           r_fill_bank;
  logic [BW-1:0]   r_wcnt;
  logic [1:0]      r_bank_full;
  logic [1:0]      w_full_nxt;
  logic [1:0]      r_state;
  bank_t           r_drain_bank;
  logic            r_rot;
  logic [ROWB-1:0] r_row;
  logic [COLB-1:0] r_col;
  logic            r_inflight;
  logic            r_inflight_last;

  logic            w_in_fire;
  logic            w_fill_wrap;
  logic            w_room;
  logic            w_issue;
  logic            w_last_rd;
  logic            w_tile_end;
  logic            w_sk_valid;
  logic [DATA_W:0] w_sk_data;
  logic [1:0]      w_occ;

  assign w_clr = rst || i_flush;

  assign bus.in_ready = !w_clr && !r_bank_full[r_fill_bank];
  assign w_in_fire    = bus.in_valid && bus.in_ready;
  assign w_fill_wrap  = w_in_fire && (&r_wcnt);

  assign o_ram_wr_en   = w_in_fire;
  assign o_ram_wr_addr = {r_fill_bank, r_wcnt};
  assign o_ram_wr_data = bus.in_data;
  assign o_ram_rd_addr = {r_drain_bank, r_row, r_col};
  assign o_bank_full   = r_bank_full;

  // Skid occupancy plus the read still in the RAM pipe must stay below 2.
  assign w_room     = (w_occ == 2'd0) || ((w_occ == 2'd1) && !r_inflight);
  assign w_issue    = (r_state == ST_READ) && w_room;
  assign w_last_rd  = (&r_row) && (&r_col);
  assign w_tile_end = (r_state == ST_WAIT) && bus.out_valid && bus.out_ready && bus.out_last;

  always_comb begin
    w_full_nxt = r_bank_full;
    if (w_fill_wrap) w_full_nxt[r_fill_bank]  = 1'b1;
    if (w_tile_end)  w_full_nxt[r_drain_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_fill_bank <= 1'b0;
      r_wcnt      <= '0;
      r_bank_full <= 2'b00;
    end else begin
      r_bank_full <= w_full_nxt;
      if (w_in_fire) begin
        r_wcnt <= r_wcnt + BW'(1);
        if (w_fill_wrap) r_fill_bank <= ~r_fill_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state         <= ST_IDLE;
      r_drain_bank    <= 1'b0;
      r_rot           <= 1'b0;
      r_row           <= '0;
      r_col           <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && w_last_rd;
      case (r_state)
        ST_IDLE: if (r_bank_full[r_drain_bank]) begin
          r_rot   <= i_rot_en;
          r_state <= ST_READ;
        end
        ST_READ: if (w_issue) begin
          // Both orders end on the same final word and wrap the counters to 0.
          if (!r_rot) begin
            r_col <= r_col + COLB'(1);
            if (&r_col) r_row <= r_row + ROWB'(1);
          end else begin
            r_row <= r_row + ROWB'(1);
            if (&r_row) r_col <= r_col + COLB'(1);
          end
          if (w_last_rd) r_state <= ST_WAIT;
        end
        ST_WAIT: if (w_tile_end) begin
          r_drain_bank <= ~r_drain_bank;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  rotate_out_skid #(.W(DATA_W + 1)) u_skid (
    .clk     (clk),
    .rst     (w_clr),
    .i_push  (r_inflight),
    .i_data  ({r_inflight_last, i_ram_rd_data}),
    .i_ready (bus.out_ready),
    .o_valid (w_sk_valid),
    .o_data  (w_sk_data),
    .o_occ   (w_occ)
  );

  assign bus.out_valid = w_sk_valid && !w_clr;
  assign bus.out_data  = w_sk_data[DATA_W-1:0];
  assign bus.out_last  = w_sk_data[DATA_W];
  assign bus.tile_done = w_tile_end;
endmodule

// File: tb/tb_rotate_buf_ctrl.sv
// Bench for rotate_buf_ctrl: behavioural RAM, tile-order scoreboard, table of
// drain scenarios and hand sequences for latency, stall, flush and mode change.
module tb_rotate_buf_ctrl;
  localparam int AW = 8;
  localparam int DW = 256;
  localparam int NR = 8;
  localparam int NC = 16;
  localparam int TW = NR * NC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          rot_en = 1'b0;
  logic [1:0]    bank_full;
  logic          wr_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  rotate_buf_ctrl_if #(.DATA_W(DW)) bus();

  rotate_buf_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ROWS(NR), .COLS(NC)) dut (
    .clk(clk), .rst(rst), .i_flush(flush), .i_rot_en(rot_en), .bus(bus),
    .o_bank_full(bank_full), .o_ram_wr_en(wr_en), .o_ram_wr_addr(wr_addr),
    .o_ram_wr_data(wr_data), .o_ram_rd_addr(rd_addr), .i_ram_rd_data(rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

  int total = 0;
  int bad = 0;
  int rdy_mode = 0;   // 0 always ready, 1 toggle, 2 random, 3 never
  int out_idx = 0;    // position inside the current output tile
  int n_out = 0;
  logic [DW-1:0] cur[$];
  logic [DW-1:0] expq[$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // A finished tile is queued in drain order: column-major reads word (k%ROWS)*COLS + k/ROWS.
  task automatic record(input logic [DW-1:0] d);
    cur.push_back(d);
    if (cur.size() == TW) begin
      for (int k = 0; k < TW; k++)
        expq.push_back(rot_en ? cur[(k % NR) * NC + k / NR] : cur[k]);
      cur.delete();
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] v;
    for (int j = 0; j < DW / 32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic push_word(input logic [DW-1:0] d, input int lim, output bit ok, output logic [AW-1:0] wa);
    ok = 1'b0;
    wa = '0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int w = 0; w < lim && !ok; w++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        wa = wr_addr;
        record(d);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic push_n(input int n, input bit seq, input int base, input int lim, output int acc);
    bit ok;
    logic [AW-1:0] wa;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      push_word(seq ? DW'(base + i) : rnd_word(), lim, ok, wa);
      if (!ok) break;
      acc++;
    end
  endtask

  task automatic wait_drain(input int lim);
    int c = 0;
    while (expq.size() != 0 && c < lim) begin
      @(posedge clk); #1;
      c++;
    end
    chk("drain_complete", DW'(expq.size() == 0), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: order, last/tile_done placement and hold-while-stalled.
  logic          prev_stall = 1'b0;
  logic [DW:0]   prev_word;
  always @(negedge clk) begin
    if (rst || flush) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", DW'(bus.out_valid), 1);
        chk("hold_data", bus.out_data, prev_word[DW-1:0]);
        chk("hold_last", DW'(bus.out_last), DW'(prev_word[DW]));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_word got=%0h want=none", bus.out_data);
        end else begin
          chk("out_data", bus.out_data, expq.pop_front());
        end
        chk("out_last", DW'(bus.out_last), DW'(out_idx == TW - 1));
        chk("tile_done", DW'(bus.tile_done), DW'(out_idx == TW - 1));
        out_idx = (out_idx + 1) % TW;
        n_out++;
      end else if (bus.tile_done) begin
        total++; bad++;
        $display("FAIL tile_done_no_hs got=1 want=0");
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_word  = {bus.out_last, bus.out_data};
    end
  end

  typedef struct {
    bit         rot;
    int         ntiles;
    int         rdy;
    bit         seq;
    int         exp_words;
    logic [1:0] exp_full;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int acc, base, c;
    bit ok;
    logic [AW-1:0] wa;

    tbl[0] = '{rot: 1'b0, ntiles: 1, rdy: 0, seq: 1'b1, exp_words: 128, exp_full: 2'b00};
    tbl[1] = '{rot: 1'b1, ntiles: 1, rdy: 0, seq: 1'b1, exp_words: 128, exp_full: 2'b00};
    tbl[2] = '{rot: 1'b0, ntiles: 2, rdy: 1, seq: 1'b0, exp_words: 256, exp_full: 2'b00};
    tbl[3] = '{rot: 1'b1, ntiles: 2, rdy: 2, seq: 1'b0, exp_words: 256, exp_full: 2'b00};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", DW'(bus.in_ready), 0);
    chk("rst_out_valid", DW'(bus.out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", DW'(bus.in_ready), 1);
    chk("post_rst_out_valid", DW'(bus.out_valid), 0);
    chk("post_rst_bank_full", DW'(bank_full), 0);
    chk("post_rst_wr_en", DW'(wr_en), 0);
    chk("post_rst_wr_addr", DW'(wr_addr), 0);
    chk("post_rst_rd_addr", DW'(rd_addr), 0);
    chk("post_rst_tile_done", DW'(bus.tile_done), 0);
    @(posedge clk); #1;

    // First-word latency after a bank fills.
    rdy_mode = 0;
    push_n(TW, 1'b0, 0, 20, acc);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_bank_full", DW'(bank_full), 1);
    chk("lat_valid_c1", DW'(bus.out_valid), 0);
    @(negedge clk);
    chk("lat_valid_c2", DW'(bus.out_valid), 0);
    @(negedge clk);
    chk("lat_valid_c3", DW'(bus.out_valid), 1);
    @(posedge clk); #1;
    wait_drain(1000);
    chk("lat_full_clear", DW'(bank_full), 0);

    for (int i = 0; i < 4; i++) begin
      rot_en   = tbl[i].rot;
      rdy_mode = tbl[i].rdy;
      base     = n_out;
      push_n(tbl[i].ntiles * TW, tbl[i].seq, 0, 50, acc);
      bus.in_valid = 1'b0;
      wait_drain(4000);
      chk("tbl_words", DW'(n_out - base), DW'(tbl[i].exp_words));
      chk("tbl_bank_full", DW'(bank_full), DW'(tbl[i].exp_full));
    end
    rot_en = 1'b0;

    // Ping-pong stall: both banks fill, then everything drains in order.
    rdy_mode = 3;
    base = n_out;
    push_n(3 * TW, 1'b1, 0, 20, acc);
    chk("pp_accepted", DW'(acc), 256);
    @(negedge clk);
    chk("pp_bank_full", DW'(bank_full), 3);
    chk("pp_in_ready", DW'(bus.in_ready), 0);
    @(posedge clk); #1;
    rdy_mode = 0;
    push_n(3 * TW - acc, 1'b1, acc, 400, c);
    bus.in_valid = 1'b0;
    wait_drain(4000);
    chk("pp_words", DW'(n_out - base), 384);
    chk("pp_full_clear", DW'(bank_full), 0);

    // Flush in the middle of a drain.
    rdy_mode = 0;
    push_n(TW, 1'b1, 0, 50, acc);
    bus.in_valid = 1'b0;
    c = 0;
    while (out_idx < 40 && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    chk("flush_reached", DW'(out_idx >= 40), 1);
    flush = 1'b1;
    expq.delete();
    cur.delete();
    out_idx = 0;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", DW'(bus.out_valid), 0);
    chk("flush_bank_full", DW'(bank_full), 0);
    @(posedge clk); #1;
    push_word(DW'(500), 10, ok, wa);
    chk("flush_first_addr", DW'(wa), 0);
    push_n(TW - 1, 1'b1, 501, 50, acc);
    bus.in_valid = 1'b0;
    wait_drain(1000);
    chk("flush_full_clear", DW'(bank_full), 0);

    // rot_en change mid-drain affects only the next tile.
    rot_en = 1'b0;
    base = n_out;
    push_n(TW, 1'b1, 1000, 50, acc);
    bus.in_valid = 1'b0;
    c = 0;
    while (n_out < base + 20 && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    rot_en = 1'b1;
    push_n(TW, 1'b1, 2000, 300, acc);
    bus.in_valid = 1'b0;
    wait_drain(2000);
    chk("rotchg_words", DW'(n_out - base), 256);
    rot_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end
endmodule
